// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Fetch stage that sits directly upstream of the MIPS main decoder. It holds
// the program counter and issues one word read at a time to a
// variable-latency instruction memory (req/ack handshake). It captures each
// returned word and offers it to decode with a valid/ready handshake.
// The next PC is either the sequential pc+4 or a redirect target that is
// sampled when decode consumes the instruction.
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   When defined, a wait counter runs while a request is outstanding. If
//   TIMEOUT_CYCLES request cycles pass without an ack, the unit sets
//   o_fetch_err (sticky) and parks in S_ERR until reset.
//   When undefined, a request waits indefinitely and o_fetch_err is tied 0.
//
// Parameters
//   RESET_PC        PC loaded on reset (bits [1:0] must be 0)
//   TIMEOUT_CYCLES  request cycles allowed without ack (macro build only)
//
// Ports
//   i_clk           system clock, all state on the rising edge
//   i_rst           synchronous, active-high reset
//   o_imem_req      read request to instruction memory
//   o_imem_addr     word-aligned read address (the current pc)
//   i_imem_ack      memory returns data this cycle
//   i_imem_rdata    instruction word, valid when i_imem_ack=1
//   o_instr         captured instruction to decoder
//   o_instr_pc      address of o_instr
//   o_pc_plus4      o_instr_pc + 4, for branch/jump target logic
//   o_instr_valid   o_instr is valid
//   i_instr_ready   downstream consumes o_instr this cycle
//   i_redirect_en   take i_redirect_pc on the consume handshake
//   i_redirect_pc   branch/jump target, low two bits forced to 0
//   o_fetch_err     sticky fetch timeout flag
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  output logic [31:0] o_pc_plus4,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  input  logic        i_redirect_en,
  input  logic [31:0] i_redirect_pc,
  output logic        o_fetch_err
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_VALID = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        w_capture;
  logic        w_consume;
  logic        w_timeout;
  logic [31:0] w_redirect_aligned;

  // Masking rather than slicing keeps the whole target bus in use while
  // guaranteeing a word-aligned fetch address.
  assign w_redirect_aligned = i_redirect_pc & 32'hFFFF_FFFC;

  // A memory ack is only meaningful while a request is outstanding; ready is
  // only meaningful while an instruction is being offered.
  assign w_capture = (r_state == S_REQ) && i_imem_ack;
  assign w_consume = (r_state == S_VALID) && i_instr_ready;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_fetch_err;

  // The counter holds the number of unacked request cycles already spent.
  // An ack on the cycle it reads TIMEOUT_CYCLES-1 still wins; without one,
  // that is the last allowed waiting cycle.
  assign w_timeout = (r_state == S_REQ) && !i_imem_ack &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Wait counter: cleared whenever no request is outstanding, so every fresh
  // entry into S_REQ starts from zero.
  always_ff @(posedge i_clk) begin
    if (i_rst || (r_state != S_REQ)) begin
      r_wait_cnt <= '0;
    end else if (!i_imem_ack) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fetch_err <= 1'b0;
    end else if (w_timeout) begin
      r_fetch_err <= 1'b1;
    end
  end

  assign o_fetch_err = r_fetch_err;
`else
  assign w_timeout   = 1'b0;
  assign o_fetch_err = 1'b0;
`endif

  // State register. Reset wins over a same-cycle ack, so that data is lost.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_next  = r_state;
    o_imem_req    = 1'b0;
    o_instr_valid = 1'b0;
    case (r_state)
      S_REQ: begin
        o_imem_req = 1'b1;
        if (i_imem_ack) begin
          w_state_next = S_VALID;
        end else if (w_timeout) begin
          w_state_next = S_ERR;
        end
      end
      S_VALID: begin
        o_instr_valid = 1'b1;
        if (i_instr_ready) begin
          w_state_next = S_REQ;
        end
      end
      S_ERR: begin
        w_state_next = S_ERR;
      end
      default: begin
        w_state_next = S_REQ;
      end
    endcase
  end

  // Program counter and captured instruction. The PC only advances on the
  // consume handshake, so the request address stays stable until the ack.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc       <= RESET_PC;
      r_instr    <= 32'h0000_0000;
      r_instr_pc <= RESET_PC;
    end else begin
      if (w_capture) begin
        r_instr    <= i_imem_rdata;
        r_instr_pc <= r_pc;
      end
      if (w_consume) begin
        r_pc <= i_redirect_en ? w_redirect_aligned : (r_pc + 32'd4);
      end
    end
  end

  assign o_imem_addr = r_pc;
  assign o_instr     = r_instr;
  assign o_instr_pc  = r_instr_pc;
  // Modulo-2^32: the top word wraps to zero.
  assign o_pc_plus4  = r_instr_pc + 32'd4;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Directed bench for instruction_fetch_unit. The main instance starts at
// PC 0 and is driven step by step; a second instance starts at the top word
// with memory and decode always ready, to show the PC wrapping to zero.
// Inputs change on the falling edge, outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic        instrReady;
  logic        redirectEn;
  logic [31:0] redirectPc;

  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] instr;
  logic [31:0] instrPc;
  logic [31:0] pcPlus4;
  logic        instrValid;
  logic        fetchErr;

  logic        wrapReq;
  logic [31:0] wrapAddr;
  logic [31:0] wrapInstr;
  logic [31:0] wrapInstrPc;
  logic [31:0] wrapPcPlus4;
  logic        wrapValid;
  logic        wrapErr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .RESET_PC      (32'h0000_0000),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_imem_req   (imemReq),
    .o_imem_addr  (imemAddr),
    .i_imem_ack   (imemAck),
    .i_imem_rdata (imemRdata),
    .o_instr      (instr),
    .o_instr_pc   (instrPc),
    .o_pc_plus4   (pcPlus4),
    .o_instr_valid(instrValid),
    .i_instr_ready(instrReady),
    .i_redirect_en(redirectEn),
    .i_redirect_pc(redirectPc),
    .o_fetch_err  (fetchErr)
  );

  instruction_fetch_unit #(
    .RESET_PC      (32'hFFFF_FFFC),
    .TIMEOUT_CYCLES(4)
  ) dutWrap (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_imem_req   (wrapReq),
    .o_imem_addr  (wrapAddr),
    .i_imem_ack   (1'b1),
    .i_imem_rdata (32'h2008_0005),
    .o_instr      (wrapInstr),
    .o_instr_pc   (wrapInstrPc),
    .o_pc_plus4   (wrapPcPlus4),
    .o_instr_valid(wrapValid),
    .i_instr_ready(1'b1),
    .i_redirect_en(1'b0),
    .i_redirect_pc(32'h0000_0000),
    .o_fetch_err  (wrapErr)
  );

  task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                               input logic ready, input logic redEn,
                               input logic [31:0] redPc);
    imemAck    = ack;
    imemRdata  = rdata;
    instrReady = ready;
    redirectEn = redEn;
    redirectPc = redPc;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge, landing on the next falling edge.
  task automatic stepCycle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    stepCycle();
    stepCycle();

    // Reset state
    checkOutput("rst_req",    32'(imemReq),    32'd1);
    checkOutput("rst_addr",   imemAddr,        32'h0);
    checkOutput("rst_valid",  32'(instrValid), 32'd0);
    checkOutput("rst_instr",  instr,           32'h0);
    checkOutput("rst_ipc",    instrPc,         32'h0);
    checkOutput("rst_plus4",  pcPlus4,         32'h4);
    checkOutput("rst_err",    32'(fetchErr),   32'd0);
    checkOutput("wrap_rst_addr", wrapAddr,     32'hFFFF_FFFC);

    // Zero-wait memory, decode always ready
    rst = 1'b0;
    applyStimulus(1'b1, 32'h2008_0005, 1'b1, 1'b0, 32'h0);
    stepCycle();
    checkOutput("c2_valid",  32'(instrValid), 32'd1);
    checkOutput("c2_instr",  instr,           32'h2008_0005);
    checkOutput("c2_ipc",    instrPc,         32'h0);
    checkOutput("c2_plus4",  pcPlus4,         32'h4);
    checkOutput("c2_req",    32'(imemReq),    32'd0);
    checkOutput("wrap_ipc",   wrapInstrPc,    32'hFFFF_FFFC);
    checkOutput("wrap_plus4", wrapPcPlus4,    32'h0);
    stepCycle();
    checkOutput("c3_addr",   imemAddr,        32'h4);
    checkOutput("c3_req",    32'(imemReq),    32'd1);
    checkOutput("c3_valid",  32'(instrValid), 32'd0);
    checkOutput("wrap_addr2", wrapAddr,       32'h0);

    // Fetch at 4, then move on to 8
    applyStimulus(1'b1, 32'h0000_1111, 1'b1, 1'b0, 32'h0);
    stepCycle();
    checkOutput("f4_ipc",    instrPc,         32'h4);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    stepCycle();

    // Memory ack delayed 3 cycles at address 8
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("dly_req%0d", i),   32'(imemReq),    32'd1);
      checkOutput($sformatf("dly_addr%0d", i),  imemAddr,        32'h8);
      checkOutput($sformatf("dly_valid%0d", i), 32'(instrValid), 32'd0);
      if (i == 3) applyStimulus(1'b1, 32'h8C09_0004, 1'b0, 1'b0, 32'h0);
      stepCycle();
    end
    checkOutput("dly_valid_up", 32'(instrValid), 32'd1);
    checkOutput("dly_instr",    instr,           32'h8C09_0004);
    checkOutput("dly_ipc",      instrPc,         32'h8);

    // Backpressure for 5 cycles; a stray ack with other data is ignored
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkOutput($sformatf("bp_instr%0d", i), instr,           32'h8C09_0004);
      checkOutput($sformatf("bp_ipc%0d", i),   instrPc,         32'h8);
      checkOutput($sformatf("bp_req%0d", i),   32'(imemReq),    32'd0);
      checkOutput($sformatf("bp_valid%0d", i), 32'(instrValid), 32'd1);
    end
    applyStimulus(1'b1, 32'h0000_0020, 1'b1, 1'b0, 32'h0);
    stepCycle();
    checkOutput("bp_next_addr", imemAddr, 32'hC);

    // Redirect pulsed during a request has no effect
    applyStimulus(1'b1, 32'h0000_0020, 1'b0, 1'b1, 32'h0000_0100);
    stepCycle();
    checkOutput("rdS_ipc",   instrPc, 32'hC);
    checkOutput("rdS_instr", instr,   32'h0000_0020);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    stepCycle();
    checkOutput("rdS_addr",  imemAddr, 32'h10);

    // Redirect on consume at 0x10 to 0x43 -> fetch from 0x40
    applyStimulus(1'b1, 32'h1000_0003, 1'b0, 1'b0, 32'h0);
    stepCycle();
    checkOutput("rd_ipc",    instrPc, 32'h10);
    checkOutput("rd_plus4",  pcPlus4, 32'h14);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0043);
    stepCycle();
    checkOutput("rd_addr",   imemAddr, 32'h40);
    applyStimulus(1'b1, 32'h0800_0000, 1'b1, 1'b0, 32'h0);
    stepCycle();
    checkOutput("rd_ipc2",   instrPc, 32'h40);
    stepCycle();
    checkOutput("rd_addr2",  imemAddr, 32'h44);

    // Reset in the same cycle as an ack: data dropped
    rst = 1'b1;
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
    stepCycle();
    checkOutput("rsta_instr", instr,           32'h0);
    checkOutput("rsta_valid", 32'(instrValid), 32'd0);
    checkOutput("rsta_addr",  imemAddr,        32'h0);
    checkOutput("rsta_ipc",   instrPc,         32'h0);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

    // No ack at all: four waiting cycles, then timeout (macro build only)
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("to_req%0d", i), 32'(imemReq),  32'd1);
      checkOutput($sformatf("to_err%0d", i), 32'(fetchErr), 32'd0);
      stepCycle();
    end
    for (int i = 0; i < 3; i++) begin
`ifdef FETCH_TIMEOUT_EN
      checkOutput($sformatf("to_err_set%0d", i), 32'(fetchErr),   32'd1);
      checkOutput($sformatf("to_req_off%0d", i), 32'(imemReq),    32'd0);
      checkOutput($sformatf("to_valid%0d", i),   32'(instrValid), 32'd0);
`else
      checkOutput($sformatf("nto_err%0d", i), 32'(fetchErr), 32'd0);
      checkOutput($sformatf("nto_req%0d", i), 32'(imemReq),  32'd1);
      checkOutput($sformatf("nto_addr%0d", i), imemAddr,     32'h0);
`endif
      stepCycle();
    end
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("to_rst_err", 32'(fetchErr), 32'd0);
    checkOutput("to_rst_req", 32'(imemReq),  32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of the main decoder in the MIPS core.
- Holds the program counter and issues word reads to a variable-latency instruction memory using a req/ack handshake.
- Captures each returned instruction and presents it to decode/control with a valid/ready handshake, so opcode = instr[31:26] feeds the decoder.
- Computes the next PC from sequential increment or from a redirect (branch/jump target) supplied when the instruction is consumed.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- TIMEOUT_CYCLES, 16, max cycles waiting for imem_ack before error; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  word-aligned read address; equals pc.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- instr  out  32  captured instruction to decoder.
- instr_pc  out  32  address of instr.
- pc_plus4  out  32  instr_pc + 4, for branch/jump target logic.
- instr_valid  out  1  instr is valid.
- instr_ready  in  1  downstream consumes instr this cycle.
- redirect_en  in  1  sampled only on the consume handshake; take redirect_pc.
- redirect_pc  in  32  branch/jump target; bits [1:0] forced to 0.
- fetch_err  out  1  sticky fetch timeout flag; tied 0 without the macro.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on rising clk. Reset overrides everything, including a same-cycle imem_ack; that data is dropped.
- Reset values:
  - pc = RESET_PC, state = S_REQ.
  - instr = 32'h0000_0000, which the decoder treats as R-type sll no-op.
  - instr_pc = RESET_PC, instr_valid = 0, fetch_err = 0, timeout counter = 0.
  - imem_req is 1 in the first cycle after reset release.
- States:
  - S_REQ:
    - imem_req = 1, imem_addr = pc; request held stable until ack.
    - On imem_ack: instr <= imem_rdata, instr_pc <= pc, go to S_VALID.
    - Ack in the same cycle as the request is legal (zero-wait memory).
  - S_VALID:
    - instr_valid = 1, imem_req = 0; instr and instr_pc held stable.
    - On instr_valid & instr_ready: pc <= redirect_en ? {redirect_pc[31:2],2'b00} : pc + 4, go to S_REQ.
  - S_ERR (macro only): imem_req = 0, instr_valid = 0; exits only via rst.
- Throughput: minimum 2 cycles per instruction (request/ack cycle, then valid/consume cycle). Latency from ack to instr_valid is 1 cycle.
- pc_plus4 = instr_pc + 4, combinational.
- Arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
- Ignored inputs:
  - imem_ack outside S_REQ is ignored.
  - redirect_en/redirect_pc outside the consume handshake are ignored.
  - instr_ready while instr_valid = 0 is ignored.
- Backpressure: instr_ready low holds S_VALID indefinitely with all outputs stable.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to S_REQ and increments each S_REQ cycle without imem_ack.
  - If the counter reaches TIMEOUT_CYCLES without ack, then next cycle: fetch_err <= 1 (sticky) and state <= S_ERR.
  - Ack on the cycle the counter reaches TIMEOUT_CYCLES-1 still succeeds.
- Without the macro: no counter, fetch_err tied 0, S_REQ waits indefinitely.

Test Plan:
- Reset release, imem_ack tied 1, imem_rdata = 32'h2008_0005 (addi), instr_ready = 1:
  - cycle 1 imem_req = 1, imem_addr = 0.
  - cycle 2 instr_valid = 1, instr = 32'h2008_0005, instr_pc = 0, pc_plus4 = 4.
  - cycle 3 imem_addr = 4.
- Memory ack delayed 3 cycles: imem_req and imem_addr = 0x8 held stable for all 4 cycles, instr_valid = 0 throughout; instr_valid rises the cycle after ack.
- instr_ready = 0 for 5 cycles in S_VALID: instr and instr_pc stable, imem_req = 0; consume on cycle 6, then imem_addr = instr_pc + 4.
- Redirect: consume at instr_pc = 0x10 with redirect_en = 1, redirect_pc = 32'h0000_0043 → next imem_addr = 32'h0000_0040. Redirect_en pulsed while in S_REQ has no effect.
- Boundaries:
  - RESET_PC = 32'hFFFF_FFFC: second fetch address is 0.
  - rst asserted in the same cycle as imem_ack: instr stays 0, instr_valid = 0, next imem_addr = RESET_PC.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES = 4, no ack: fetch_err = 1 after 4 waiting cycles, imem_req = 0 thereafter; rst clears both. Without the macro, fetch_err stays 0 and imem_req stays 1.
